// File: rtl/bubble_sort_ctrl.sv
// Bubble-sort sequencing controller: serially loads N words, sorts them in
// place with one compare-swap per clock on a shared comparator, then streams
// the sorted set out with valid/ready handshaking.
module bubble_sort_ctrl #(
   parameter int WIDTH   = 4,
   parameter int N       = 4,
   parameter bit DESCEND = 1'b0
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_last,
   output logic             busy,
   output logic [7:0]       swap_count
);

   localparam int            IW       = (N > 2) ? $clog2(N) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
   localparam logic [IW-1:0] LAST_CMP = IW'(N - 2);

   typedef enum logic [1:0] {
      LOAD = 2'd0,
      SORT = 2'd1,
      OUT  = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_mem [N];
   logic [IW-1:0]    r_wr_idx;
   logic [IW-1:0]    r_rd_idx;
   logic [IW-1:0]    r_pass;
   logic [IW-1:0]    r_cmp;
   logic             r_swapped;
   logic [7:0]       r_swap_count;

   logic [IW-1:0]    w_cmp_nxt;
   logic [WIDTH-1:0] w_lo;
   logic [WIDTH-1:0] w_hi;
   logic             w_swap;
   logic             w_pass_end;

   // Shared comparator on the adjacent pair selected by the compare index
   always_comb begin
      w_cmp_nxt  = r_cmp + IW'(1);
      w_lo       = r_mem[r_cmp];
      w_hi       = r_mem[w_cmp_nxt];
      w_swap     = DESCEND ? (w_lo < w_hi) : (w_lo > w_hi);
      w_pass_end = (r_cmp == (LAST_CMP - r_pass));
   end

   // State register
   always_ff @(posedge CLK) begin
      if (RST) r_state <= LOAD;
      else     r_state <= w_state_nxt;
   end

   // Next-state decode and registered-state output decode; reset forces outputs idle
   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      out_data    = '0;
      out_last    = 1'b0;
      busy        = 1'b0;
      case (r_state)
         LOAD: begin
            in_ready = 1'b1;
            if (in_valid && (r_wr_idx == LAST_IDX)) w_state_nxt = SORT;
         end
         SORT: begin
            busy = 1'b1;
            // The current compare's swap counts toward this pass's flag
            if (w_pass_end && (!(r_swapped || w_swap) || (r_pass == LAST_CMP)))
               w_state_nxt = OUT;
         end
         OUT: begin
            out_valid = 1'b1;
            out_data  = r_mem[r_rd_idx];
            out_last  = (r_rd_idx == LAST_IDX);
            if (out_ready && (r_rd_idx == LAST_IDX)) w_state_nxt = LOAD;
         end
         default: w_state_nxt = LOAD;
      endcase
      if (RST) begin
         in_ready  = 1'b0;
         out_valid = 1'b0;
         out_data  = '0;
         out_last  = 1'b0;
         busy      = 1'b0;
      end
   end

   // Register file: serial load writes, sort swaps both words at the same edge
   always_ff @(posedge CLK) begin
      if (!RST) begin
         if ((r_state == LOAD) && in_valid) begin
            r_mem[r_wr_idx] <= in_data;
         end else if ((r_state == SORT) && w_swap) begin
            r_mem[r_cmp]     <= w_hi;
            r_mem[w_cmp_nxt] <= w_lo;
         end
      end
   end

   // Write/read/pass/compare indices, per-pass swap flag and swap counter
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_wr_idx     <= '0;
         r_rd_idx     <= '0;
         r_pass       <= '0;
         r_cmp        <= '0;
         r_swapped    <= 1'b0;
         r_swap_count <= '0;
      end else begin
         case (r_state)
            LOAD: begin
               r_pass    <= '0;
               r_cmp     <= '0;
               r_swapped <= 1'b0;
               if (in_valid) begin
                  r_wr_idx <= (r_wr_idx == LAST_IDX) ? '0 : r_wr_idx + IW'(1);
               end
            end
            SORT: begin
               if (w_swap) begin
                  r_swapped <= 1'b1;
                  if (r_swap_count != 8'hFF) r_swap_count <= r_swap_count + 8'd1;
               end
               if (w_pass_end) begin
                  r_pass    <= r_pass + IW'(1);
                  r_cmp     <= '0;
                  r_swapped <= 1'b0;
               end else begin
                  r_cmp <= w_cmp_nxt;
               end
            end
            OUT: begin
               if (out_ready) begin
                  if (r_rd_idx == LAST_IDX) begin
                     r_rd_idx     <= '0;
                     r_swap_count <= '0;
                  end else begin
                     r_rd_idx <= r_rd_idx + IW'(1);
                  end
               end
            end
            default: begin
               r_wr_idx <= '0;
               r_rd_idx <= '0;
            end
         endcase
      end
   end

   assign swap_count = r_swap_count;

endmodule

// File: tb/tb_bubble_sort_ctrl.sv
// Testbench for bubble_sort_ctrl: one ascending and one descending instance,
// directed sets from the test plan plus random sets, checked against a
// behavioural sorting model (sorted order, inversion count, pass count).
module tb_bubble_sort_ctrl;

   localparam int W  = 4;
   localparam int NW = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         sel;
   logic         in_valid;
   logic [W-1:0] in_data;
   logic         out_ready;

   logic         iv0, iv1, ir0, ir1, ov0, ov1, or0, or1, ol0, ol1, b0, b1;
   logic [W-1:0] od0, od1;
   logic [7:0]   sc0, sc1;

   logic         o_in_ready, o_out_valid, o_out_last, o_busy;
   logic [W-1:0] o_out_data;
   logic [7:0]   o_swap_count;

   int total = 0;
   int bad   = 0;
   int cur     [NW];
   int exp_srt [NW];

   always #5 clk = ~clk;

   assign iv0 = in_valid & ~sel;
   assign iv1 = in_valid & sel;
   assign or0 = out_ready & ~sel;
   assign or1 = out_ready & sel;

   assign o_in_ready   = sel ? ir1 : ir0;
   assign o_out_valid  = sel ? ov1 : ov0;
   assign o_out_data   = sel ? od1 : od0;
   assign o_out_last   = sel ? ol1 : ol0;
   assign o_busy       = sel ? b1  : b0;
   assign o_swap_count = sel ? sc1 : sc0;

   bubble_sort_ctrl #(.WIDTH(W), .N(NW), .DESCEND(1'b0)) dut_asc (
      .CLK(clk), .RST(rst),
      .in_valid(iv0), .in_ready(ir0), .in_data(in_data),
      .out_valid(ov0), .out_ready(or0), .out_data(od0), .out_last(ol0),
      .busy(b0), .swap_count(sc0)
   );

   bubble_sort_ctrl #(.WIDTH(W), .N(NW), .DESCEND(1'b1)) dut_desc (
      .CLK(clk), .RST(rst),
      .in_valid(iv1), .in_ready(ir1), .in_data(in_data),
      .out_valid(ov1), .out_ready(or1), .out_data(od1), .out_last(ol1),
      .busy(b1), .swap_count(sc1)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d (sel=%0d)", tag, obs, expv, sel);
      end
   endtask

   // Reference: sorted order, swaps = strict inversions, passes from the
   // largest count of out-of-order predecessors of any element.
   task automatic model(input bit desc, output int swaps, output int cyc);
      int q[$];
      int maxl, cntl, passes;
      q = {};
      for (int i = 0; i < NW; i++) q.push_back(cur[i]);
      if (desc) q.rsort();
      else      q.sort();
      for (int i = 0; i < NW; i++) exp_srt[i] = q[i];
      swaps = 0;
      maxl  = 0;
      for (int j = 0; j < NW; j++) begin
         cntl = 0;
         for (int i = 0; i < j; i++)
            if (desc ? (cur[i] < cur[j]) : (cur[i] > cur[j])) cntl++;
         swaps += cntl;
         if (cntl > maxl) maxl = cntl;
      end
      if (swaps > 255) swaps = 255;
      passes = (maxl + 1 < NW - 1) ? maxl + 1 : NW - 1;
      cyc = 0;
      for (int p = 0; p < passes; p++) cyc += NW - 1 - p;
   endtask

   task automatic load_set();
      for (int i = 0; i < NW; i++) begin
         @(negedge clk);
         chk("in_ready_load", o_in_ready, 1);
         chk("out_valid_load", o_out_valid, 0);
         in_valid = 1'b1;
         in_data  = W'(cur[i]);
      end
   endtask

   task automatic run_set(input int stall_at, input bit garbage, input bit rand_ready);
      int swaps, cyc, bcnt, k, guard, stall_n;
      model(sel, swaps, cyc);
      load_set();
      @(negedge clk);
      in_valid = garbage;
      in_data  = W'($urandom_range(0, 15));
      bcnt = 0;
      while (o_busy === 1'b1 && bcnt < 100) begin
         chk("in_ready_sort", o_in_ready, 0);
         bcnt++;
         @(negedge clk);
         in_data = W'($urandom_range(0, 15));
      end
      chk("busy_cycles", bcnt, cyc);
      chk("swap_count", o_swap_count, swaps);
      k = 0;
      guard = 0;
      stall_n = 0;
      while (k < NW && guard < 200) begin
         guard++;
         chk("out_valid", o_out_valid, 1);
         chk("out_data", o_out_data, exp_srt[k]);
         chk("out_last", o_out_last, (k == NW - 1));
         chk("in_ready_out", o_in_ready, 0);
         chk("swap_count_out", o_swap_count, swaps);
         if ((k == stall_at && stall_n < 3) || (rand_ready && $urandom_range(0, 2) == 0)) begin
            out_ready = 1'b0;
            if (k == stall_at) stall_n++;
         end else begin
            out_ready = 1'b1;
            k++;
            if (k == NW) in_valid = 1'b0;
         end
         in_data = W'($urandom_range(0, 15));
         @(negedge clk);
      end
      chk("out_words", k, NW);
      in_valid  = 1'b0;
      out_ready = 1'b0;
      chk("in_ready_back", o_in_ready, 1);
      chk("out_valid_back", o_out_valid, 0);
      chk("out_data_idle", o_out_data, 0);
      chk("swap_count_clr", o_swap_count, 0);
   endtask

   initial begin
      rst       = 1'b1;
      sel       = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_in_ready", o_in_ready, 0);
      chk("rst_out_valid", o_out_valid, 0);
      chk("rst_busy", o_busy, 0);
      chk("rst_out_data", o_out_data, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_in_ready", o_in_ready, 1);
      chk("post_rst_swap_count", o_swap_count, 0);
      chk("post_rst_out_last", o_out_last, 0);

      // Ascending directed sets
      cur = '{3, 1, 2, 0};     run_set(-1, 1'b0, 1'b0);
      cur = '{1, 2, 3, 4};     run_set(-1, 1'b0, 1'b0);
      cur = '{15, 10, 5, 0};   run_set(-1, 1'b0, 1'b0);
      cur = '{7, 7, 2, 7};     run_set(-1, 1'b0, 1'b0);
      // Backpressure at word 2 with garbage offered during SORT and OUT
      cur = '{12, 3, 9, 5};    run_set(2, 1'b1, 1'b0);

      // Descending instance
      sel = 1'b1;
      @(negedge clk);
      cur = '{15, 10, 5, 0};   run_set(-1, 1'b0, 1'b0);
      cur = '{3, 1, 2, 0};     run_set(2, 1'b1, 1'b0);

      // Reset in the middle of SORT
      sel = 1'b0;
      @(negedge clk);
      cur = '{3, 1, 2, 0};
      load_set();
      @(negedge clk);
      in_valid = 1'b0;
      chk("mid_busy", o_busy, 1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_in_ready", o_in_ready, 0);
      chk("mid_rst_busy", o_busy, 0);
      chk("mid_rst_out_valid", o_out_valid, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("mid_after_in_ready", o_in_ready, 1);
      chk("mid_after_busy", o_busy, 0);
      chk("mid_after_out_valid", o_out_valid, 0);
      chk("mid_after_swap_count", o_swap_count, 0);
      cur = '{9, 4, 6, 1};     run_set(-1, 1'b0, 1'b0);

      // Random sets on both instances with random backpressure and garbage
      for (int r = 0; r < 24; r++) begin
         sel = (r % 2 == 1);
         @(negedge clk);
         for (int i = 0; i < NW; i++) cur[i] = int'($urandom_range(0, 15));
         run_set(-1, 1'($urandom_range(0, 1)), 1'b1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/bubble_sort_ctrl.md
Name: bubble_sort_ctrl

Overview:
- Sequencing controller for the sorting datapath.
- Accepts a set of N unsigned WIDTH-bit words serially and stores them in an internal register file.
- Sorts them in place with bubble sort: one compare-swap per clock on a single shared comparator plus a 2:1 word mux pair.
- Streams the sorted set back out serially with valid/ready handshakes on both sides; sits between a word source and a word sink.

Parameters:
- WIDTH, 4, bit width of each data word (unsigned).
- N, 4, words per set; legal range 2..16.
- DESCEND, 0, 0 = ascending output order, 1 = descending.

Ports:
- CLK  input  1  clock; all state changes on rising edge.
- RST  input  1  synchronous reset, active-high.
- in_valid  input  1  source presents in_data.
- in_ready  output  1  controller accepts a word this cycle.
- in_data  input  WIDTH  input word.
- out_valid  output  1  out_data holds a sorted word.
- out_ready  input  1  sink accepts out_data this cycle.
- out_data  output  WIDTH  sorted output word.
- out_last  output  1  marks the final word of the set.
- busy  output  1  high while in SORT.
- swap_count  output  8  number of swaps performed for the current set.

Behaviour:
- States: LOAD, SORT, OUT. Reset state is LOAD.
- Reset (RST high at an edge, any state, including mid-SORT or mid-OUT):
  - next state LOAD; write, read, pass and compare indices cleared; swap_count = 0.
  - Stored words are discarded; register contents are don't-care.
  - While RST is high: in_ready = 0, out_valid = 0, out_data = 0, out_last = 0, busy = 0.
- LOAD:
  - in_ready = 1.
  - Each cycle with in_valid && in_ready writes in_data to reg[wr_idx], then wr_idx++.
  - The N-th accept moves to SORT on the next cycle; wr_idx returns to 0.
  - out_valid = 0, busy = 0.
- SORT:
  - in_ready = 0; in_valid is ignored, no data lost or stored. busy = 1.
  - Indices: pass p in 0..N-2, compare index j in 0..N-2-p; both 0 on entry.
  - Each cycle compares reg[j] with reg[j+1]. Swap if reg[j] > reg[j+1] (DESCEND = 0) or reg[j] < reg[j+1] (DESCEND = 1).
  - Equal words never swap (stable sort).
  - On a swap, both registers update at the same edge via the mux pair, swap_count increments (saturates at 255), and the per-pass swap flag is set.
  - At j == N-2-p (end of pass):
    - Go to OUT if the pass had no swap (early exit) or p == N-2.
    - Otherwise p++, j = 0, swap flag cleared.
  - Cycle counts: sorted input takes N-1 SORT cycles; worst case takes N(N-1)/2.
- OUT:
  - out_valid = 1, out_data = reg[rd_idx], out_last = (rd_idx == N-1).
  - out_valid, out_data and out_last are held stable while out_ready = 0.
  - Each out_valid && out_ready handshake increments rd_idx.
  - The handshake with out_last = 1 returns to LOAD next cycle, clears rd_idx, and clears swap_count.
  - swap_count is stable throughout OUT. in_ready = 0.
- Outside OUT: out_data = 0, out_last = 0.
- All outputs decode from registered state; no combinational path from in_valid or out_ready to any output.

Test Plan:
- Reset, load 3,1,2,0 (ascending):
  - busy high exactly 6 cycles, swap_count = 5.
  - Output 0,1,2,3; out_last only on the word 3.
- Load 1,2,3,4:
  - busy high exactly 3 cycles (early exit), swap_count = 0.
  - Output 1,2,3,4.
- Load 15,10,5,0:
  - busy 6 cycles, swap_count = 6, output 0,5,10,15.
  - With DESCEND = 1, the same input gives busy 3 cycles, swap_count 0, output 15,10,5,0.
- Load 7,7,2,7:
  - Output 2,7,7,7, swap_count = 2, busy 6 cycles.
- Backpressure and ignored input:
  - Hold out_ready = 0 for 3 cycles at word 2: out_data and out_valid stay stable, no word is skipped or repeated.
  - Keep in_valid = 1 with garbage data during SORT and OUT: output is unaffected, in_ready stays 0.
- Reset mid-operation:
  - Assert RST for 1 cycle during SORT: next cycle in_ready = 1, out_valid = 0, busy = 0, swap_count = 0.
  - Then load 9,4,6,1: output 1,4,6,9.
